// File: rtl/prm_oblgc_scan.sv
// Obstacle-code sequencer for the prm_oblgc_chk* edge-checker bank: ORs edge masks into a bitmap, then reads it out.
// Optional build macro PRM_OBLGC_SCAN_DEDUP_EN suppresses re-presenting a code equal to the one already on the bus.
module prm_oblgc_scan #(
    parameter int NUM_EDGE = 1024,
    parameter int OUT_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                obs_valid,
    output logic                obs_ready,
    input  logic [14:0]         obs_code,
    input  logic                obs_last,
    output logic [14:0]         chk_code,
    output logic                chk_strobe,
    input  logic [NUM_EDGE-1:0] chk_mask,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [OUT_W-1:0]    rd_data,
    output logic                rd_last,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    obs_count
);

    localparam int NUM_WORDS = NUM_EDGE / OUT_W;
    localparam int PTR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_READ,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_EDGE-1:0] bitmap_q, bitmap_d;
    logic [14:0]         chk_code_q, chk_code_d;
    logic                chk_strobe_q, chk_strobe_d;
    logic [CNT_W-1:0]    obs_count_q, obs_count_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                obs_hs;
    logic                rd_hs;
    logic                present;

    assign obs_hs = (state_q == S_SCAN) && obs_valid;
    assign rd_hs  = (state_q == S_READ) && rd_ready;

`ifdef PRM_OBLGC_SCAN_DEDUP_EN
    // first_q forces the opening code of a scan onto the bus even if it matches stale chk_code.
    logic first_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            first_q <= 1'b1;
        end else if (obs_hs) begin
            first_q <= 1'b0;
        end
    end

    assign present = first_q || (obs_code != chk_code_q);
`else
    assign present = 1'b1;
`endif

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        bitmap_d     = bitmap_q;
        chk_code_d   = chk_code_q;
        chk_strobe_d = 1'b0;
        obs_count_d  = obs_count_q;
        ptr_d        = ptr_q;

        if (chk_strobe_q) begin
            bitmap_d = bitmap_q | chk_mask;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bitmap_d    = '0;
                    obs_count_d = '0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (obs_hs) begin
                    if (present) begin
                        chk_code_d   = obs_code;
                        chk_strobe_d = 1'b1;
                    end
                    if (obs_count_q != '1) begin
                        obs_count_d = obs_count_q + 1'b1;
                    end
                    if (obs_last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            // One idle cycle lets the mask of the final presented code land in the bitmap.
            S_FLUSH: state_d = S_READ;
            S_READ: begin
                if (rd_hs) begin
                    if (ptr_q == LAST_PTR) begin
                        state_d = S_FIN;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                ptr_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the bitmap is ordinary flops, not a RAM, so clearing it in reset is cheap and keeps readout defined.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bitmap_q     <= '0;
            chk_code_q   <= '0;
            chk_strobe_q <= 1'b0;
            obs_count_q  <= '0;
            ptr_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            bitmap_q     <= bitmap_d;
            chk_code_q   <= chk_code_d;
            chk_strobe_q <= chk_strobe_d;
            obs_count_q  <= obs_count_d;
            ptr_q        <= ptr_d;
        end
    end

    assign obs_ready  = (state_q == S_SCAN);
    assign chk_code   = chk_code_q;
    assign chk_strobe = chk_strobe_q;
    assign rd_valid   = (state_q == S_READ);
    assign rd_data    = bitmap_q[int'(ptr_q) * OUT_W +: OUT_W];
    assign rd_last    = (state_q == S_READ) && (ptr_q == LAST_PTR);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign obs_count  = obs_count_q;

endmodule

// File: tb/tb_prm_oblgc_scan.sv
// Scoreboard bench for prm_oblgc_scan: stimulus pushes expected readout words, a negedge monitor pops and compares.
module tb_prm_oblgc_scan;

    localparam int NUM_EDGE = 64;
    localparam int OUT_W    = 32;
    localparam int CNT_W    = 16;
    localparam int NWORDS   = NUM_EDGE / OUT_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                obs_valid = 1'b0;
    logic                obs_ready;
    logic [14:0]         obs_code = '0;
    logic                obs_last = 1'b0;
    logic [14:0]         chk_code;
    logic                chk_strobe;
    logic [NUM_EDGE-1:0] chk_mask;
    logic                rd_valid;
    logic                rd_ready = 1'b0;
    logic [OUT_W-1:0]    rd_data;
    logic                rd_last;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    obs_count;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    int          exp_cnt_q[$];
    logic [14:0] codes_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          strobe_total = 0;
    bit          pend_done = 1'b0;

    always #5 clk = ~clk;

    // Stand-in checker bank: code 0x7FFF blocks every edge, otherwise one edge selected by code mod 64.
    function automatic logic [NUM_EDGE-1:0] mask_of(input logic [14:0] c);
        if (c == 15'h7FFF) return '1;
        return 64'h1 << (c % 15'd64);
    endfunction

    assign chk_mask = mask_of(chk_code);

    prm_oblgc_scan #(.NUM_EDGE(NUM_EDGE), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_code(obs_code), .obs_last(obs_last),
        .chk_code(chk_code), .chk_strobe(chk_strobe), .chk_mask(chk_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done), .obs_count(obs_count)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares readout words, the done pulse and the final obs_count.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_done = 1'b0;
            end else begin
                if (chk_strobe) strobe_total++;
                if (done || pend_done) check(done == pend_done, "done_pulse", 64'(done), 64'(pend_done));
                if (done) begin
                    if (exp_cnt_q.size() == 0) check(1'b0, "done_unexpected", 64'(done), 64'd0);
                    else begin
                        int c;
                        c = exp_cnt_q.pop_front();
                        check(obs_count == CNT_W'(c), "obs_count", 64'(obs_count), 64'(c));
                    end
                end
                pend_done = rd_valid && rd_ready && rd_last;
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) check(1'b0, "rd_unexpected", 64'(rd_data), 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        check(rd_data == e.data, "rd_data", 64'(rd_data), 64'(e.data));
                        check(rd_last == e.last, "rd_last", 64'(rd_last), 64'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one complete scan of codes_q; stall holds rd_ready low that many READ cycles, poke pulses start meanwhile.
    task automatic run_scan(input int stall, input bit poke, input bit rnd_ready);
        logic [NUM_EDGE-1:0] bm;
        int exp_strobes, base, flush_cycles, guard;
        logic [OUT_W-1:0] d0;
        logic l0;
        bit ok, seen;
        bm = '0;
        exp_strobes = 0;
        foreach (codes_q[i]) begin
            bm |= mask_of(codes_q[i]);
`ifdef PRM_OBLGC_SCAN_DEDUP_EN
            if (i == 0 || codes_q[i] != codes_q[i-1]) exp_strobes++;
`else
            exp_strobes++;
`endif
        end
        for (int k = 0; k < NWORDS; k++) begin
            rd_exp_t e;
            e.data = bm[k*OUT_W +: OUT_W];
            e.last = (k == NWORDS - 1);
            exp_q.push_back(e);
        end
        exp_cnt_q.push_back(codes_q.size());

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        base = strobe_total;
        foreach (codes_q[i]) begin
            obs_valid = 1'b1;
            obs_code  = codes_q[i];
            obs_last  = (i == codes_q.size() - 1);
            guard = 0;
            do begin
                @(negedge clk);
                ok = obs_ready;
                @(posedge clk); #1;
                guard++;
            end while (!ok && guard < 20);
            if (!ok) check(1'b0, "obs_ready_timeout", 64'(guard), 64'd20);
        end
        obs_valid = 1'b0;
        obs_last  = 1'b0;

        flush_cycles = 0;
        forever begin
            @(negedge clk);
            if (rd_valid || flush_cycles > 8) break;
            check(busy && !obs_ready, "flush_state", 64'({busy, obs_ready}), 64'b10);
            flush_cycles++;
        end
        check(flush_cycles == 1, "flush_len", 64'(flush_cycles), 64'd1);

        d0 = rd_data;
        l0 = rd_last;
        for (int s = 0; s < stall; s++) begin
            if (poke && s == 1) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            check(rd_valid && busy && rd_data == d0 && rd_last == l0, "rd_hold",
                  64'(rd_data), 64'(d0));
        end

        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1 rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            seen = done;
        end
        check(seen, "done_timeout", 64'(seen), 64'd1);
        @(posedge clk); #1 rd_ready = 1'b0;
        check(strobe_total - base == exp_strobes, "strobe_count", 64'(strobe_total - base), 64'(exp_strobes));
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check({busy, obs_ready, rd_valid, rd_last, done, chk_strobe} == 6'b0, "reset_flags",
              64'({busy, obs_ready, rd_valid, rd_last, done, chk_strobe}), 64'd0);
        check(obs_count == '0 && chk_code == '0, "reset_regs", 64'({obs_count, chk_code}), 64'd0);

        // Two codes: bits 1 and 52.
        codes_q = '{15'h0001, 15'h1234};
        run_scan(0, 1'b0, 1'b0);

        // Single all-blocking code.
        codes_q = '{15'h7FFF};
        run_scan(0, 1'b0, 1'b0);

        // Backpressure for 5 cycles with start poked during READ.
        codes_q = '{15'h0003, 15'h0021, 15'h003F};
        run_scan(5, 1'b1, 1'b0);

        // Reset mid-scan after three codes.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs_valid = 1'b1;
            obs_code  = 15'(40 + i);
            @(posedge clk); #1;
        end
        obs_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check(!busy && !obs_ready && !chk_strobe && !rd_valid, "midscan_reset_flags",
              64'({busy, obs_ready, chk_strobe, rd_valid}), 64'd0);
        check(obs_count == '0, "midscan_reset_count", 64'(obs_count), 64'd0);
        codes_q = '{15'h000A};
        run_scan(0, 1'b0, 1'b0);

        // Repeated code: dedup build strobes once, plain build three times.
        codes_q = '{15'h0005, 15'h0005, 15'h0005};
        run_scan(0, 1'b0, 1'b0);

        // obs_valid while IDLE is ignored.
        obs_valid = 1'b1;
        obs_code  = 15'h0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(!obs_ready && !busy && !chk_strobe && !rd_valid, "idle_ignore",
                  64'({obs_ready, busy, chk_strobe, rd_valid}), 64'd0);
            check(obs_count == CNT_W'(3), "idle_count", 64'(obs_count), 64'd3);
        end
        obs_valid = 1'b0;

        // Randomized scans with occasional repeats and random rd_ready.
        for (int t = 0; t < 8; t++) begin
            codes_q = {};
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) codes_q.push_back(codes_q[i-1]);
                else codes_q.push_back(15'($urandom_range(0, 32767)));
            end
            run_scan($urandom_range(0, 3), 1'b0, 1'b1);
        end

        repeat (3) @(posedge clk);
        check(exp_q.size() == 0, "exp_q_drained", 64'(exp_q.size()), 64'd0);
        check(exp_cnt_q.size() == 0, "cnt_q_drained", 64'(exp_cnt_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
